rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between NUM_SRC writeback sources (ALU, LSU, MUL/DIV).
//  Each source uses a valid/ready handshake; one source is granted per cycle.
//  The grant is registered onto the RF write port.
//  Also keeps a 32-entry pending-write scoreboard (o_busy). Issue sets a bit; writeback acceptance
//  clears it. Decode uses o_busy for RAW stalls.
// PARAMETERS
//  XLEN     32  data width of the RF write port
//  NUM_SRC  3   number of writeback sources; legal range 2..8; source 0 = ALU
// PORTS
//  i_clk           in   1             clock; all state updates on its rising edge
//  i_rst_n         in   1             synchronous active-low reset, sampled on rising i_clk
//  i_wb_valid      in   NUM_SRC       per-source writeback request
//  o_wb_ready      out  NUM_SRC       per-source grant; onehot0
//  i_wb_rd         in   NUM_SRC*5     per-source destination register, packed, src0 at LSBs
//  i_wb_data       in   NUM_SRC*XLEN  per-source writeback data, packed, src0 at LSBs
//  i_issue_valid   in   1             an instruction with a destination register issues this cycle
//  i_issue_rd      in   5             destination register of the issuing instruction
//  o_rf_reg_write  out  1             RF write enable (registered)
//  o_rf_rd         out  5             RF write address (registered)
//  o_rf_rd_din     out  XLEN          RF write data (registered)
//  o_busy          out  32            scoreboard; bit r=1 means a write to xr is pending; bit 0 always 0
// BEHAVIOUR
//  - Reset (i_rst_n=0 at an edge):
//      o_rf_reg_write=0, o_rf_rd=0, o_rf_rd_din=0, o_busy=0, RR pointer=0.
//      Any in-flight transfer is dropped.
//      o_wb_ready is combinational and is held at 0 while i_rst_n=0.
//  - Handshake rules:
//      A transfer occurs when i_wb_valid[i] && o_wb_ready[i].
//      o_wb_ready[i] depends only on i_wb_valid and the arbiter state, never on data.
//      A source holds valid, rd and data stable until accepted. A source must not drop valid before acceptance.
//  - Arbitration: at most one ready bit high per cycle. o_wb_ready=0 when no valid is high.
//  - Latency: a transfer accepted at edge N drives o_rf_* during cycle N+1.
//      The RF commits the write at edge N+1.
//      The RF's same-cycle read bypass forwards the data during cycle N+1.
//      With no transfer at edge N, o_rf_reg_write=0 in cycle N+1.
//      o_rf_rd and o_rf_rd_din then hold their previous values.
//  - Back-to-back transfers: full throughput, one transfer per cycle, no bubbles.
//  - x0: a transfer with rd=0 is accepted normally and consumes the grant.
//      It drives o_rf_reg_write=0 in cycle N+1.
//  - Scoreboard bit update at each edge, for r = 1..31:
//      busy[r] <= set[r] | (busy[r] & ~clr[r])
//      set[r] = i_issue_valid && i_issue_rd==r
//      clr[r] = transfer accepted with rd==r
//      If set and clear hit the same r in one cycle, set wins (a newer producer is pending).
//      Issue with rd=0 is ignored.
//      Clearing at acceptance is safe because the bypass covers cycle N+1.
//  - Issue to a register that is already busy (WAW): the bit stays 1.
//      Decode does not issue WAW, and the block takes no other action.
// CONFIGURATION
//  RF_WB_RR_ARB_EN defined:
//      Round-robin. Priority starts at (last granted + 1) mod NUM_SRC.
//      The pointer updates only on an accepted transfer; idle cycles leave it unchanged.
//  RF_WB_RR_ARB_EN undefined:
//      Fixed priority. The lowest-index valid source wins; no pointer state.
//      A held high-priority source may starve the others.
// STRUCTURE
//  - Package rf_pkg:
//      localparam REG_ADDR_W=5, localparam NUM_REGS=32
//      typedef logic [REG_ADDR_W-1:0] reg_addr_t
//      typedef logic [NUM_REGS-1:0] reg_mask_t
//  - Sub-module rf_wb_rr_arb:
//      inputs req[NUM_SRC], advance; output onehot0 gnt[NUM_SRC]
//      contains the pointer and the macro-selected priority logic
//  - Top level: grant mux, output register, scoreboard.
// TESTING
//  1. Reset mid-transfer:
//     src1 valid, rd=5; assert i_rst_n=0 for 1 cycle.
//     Expect o_rf_reg_write=0, o_busy=0 and ready=0 during reset; the transfer is not committed.
//  2. Single source:
//     issue rd=7 at cycle 0; src2 valid rd=7 data=0xDEADBEEF at cycle 3.
//     Expect o_busy[7]=1 in cycles 1..3, ready[2]=1 in cycle 3.
//     Cycle 4: o_rf_reg_write=1, o_rf_rd=7, o_rf_rd_din=0xDEADBEEF, o_busy[7]=0.
//  3. Contention, all three sources valid and held (rd=1,2,3):
//     RR: grants 0,1,2 on consecutive cycles.
//     Fixed priority: grants 0,1,2 in that order, with src0 re-grant first if it re-asserts.
//  4. Simultaneous set and clear:
//     issue rd=9 in the same cycle src0 is accepted with rd=9.
//     Expect o_busy[9]=1 afterwards.
//  5. x0:
//     src1 valid rd=0 data=0x1234 is accepted; next cycle o_rf_reg_write=0.
//     Issue rd=0 leaves o_busy[0]=0.
//  6. Hold rule:
//     src0 valid with no competitor gets ready in the same cycle.
//     With src0 data changing every cycle, each accepted beat appears once on o_rf_rd_din, in order.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file address and mask types shared by the writeback path
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;
endpackage

// File: rtl/rf_wb_rr_arb.sv
// rtl/rf_wb_rr_arb.sv - onehot0 writeback grant; round-robin when RF_WB_RR_ARB_EN is defined, else fixed priority
module rf_wb_rr_arb #(
  parameter int NUM_SRC = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] gnt
);
`ifdef RF_WB_RR_ARB_EN
  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Search starts at ptr, which already holds (last granted + 1) mod NUM_SRC.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{i_clk, i_rst_n, advance};

  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - RF write-port arbiter with pending-write scoreboard; RF_WB_RR_ARB_EN selects round-robin
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_SRC-1:0]           i_wb_valid,
  output logic [NUM_SRC-1:0]           o_wb_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_wb_rd,
  input  logic [NUM_SRC*XLEN-1:0]      i_wb_data,
  input  logic                         i_issue_valid,
  input  logic [REG_ADDR_W-1:0]        i_issue_rd,
  output logic                         o_rf_reg_write,
  output logic [REG_ADDR_W-1:0]        o_rf_rd,
  output logic [XLEN-1:0]              o_rf_rd_din,
  output logic [NUM_REGS-1:0]          o_busy
);
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic               accept;
  reg_addr_t          sel_rd;
  logic [XLEN-1:0]    sel_data;
  reg_mask_t          busy;
  reg_mask_t          set_mask;
  reg_mask_t          clr_mask;

  // Gating requests with reset keeps every ready low while reset is asserted.
  assign req = i_wb_valid & {NUM_SRC{i_rst_n}};

  rf_wb_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign o_wb_ready = gnt;
  assign accept     = |gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_rd   = i_wb_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = i_wb_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_reg_write <= 1'b0;
      o_rf_rd        <= '0;
      o_rf_rd_din    <= '0;
    end else if (accept) begin
      o_rf_reg_write <= (sel_rd != '0);
      o_rf_rd        <= sel_rd;
      o_rf_rd_din    <= sel_data;
    end else begin
      o_rf_reg_write <= 1'b0;
    end
  end

  // Set overrides clear on the same register: the newer producer is still outstanding.
  assign set_mask = (i_issue_valid && i_issue_rd != '0) ? (reg_mask_t'(1) << i_issue_rd) : '0;
  assign clr_mask = accept ? (reg_mask_t'(1) << sel_rd) : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy <= '0;
    end else begin
      busy <= set_mask | (busy & ~clr_mask);
    end
  end

  assign o_busy = busy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a queue-based reference model
module tb_rf_wb_arbiter;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 3;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [NUM_SRC-1:0]      i_wb_valid;
  logic [NUM_SRC-1:0]      o_wb_ready;
  logic [NUM_SRC*5-1:0]    i_wb_rd;
  logic [NUM_SRC*XLEN-1:0] i_wb_data;
  logic                    i_issue_valid;
  logic [4:0]              i_issue_rd;
  logic                    o_rf_reg_write;
  logic [4:0]              o_rf_rd;
  logic [XLEN-1:0]         o_rf_rd_din;
  logic [31:0]             o_busy;

  rf_wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_wb_valid     (i_wb_valid),
    .o_wb_ready     (o_wb_ready),
    .i_wb_rd        (i_wb_rd),
    .i_wb_data      (i_wb_data),
    .i_issue_valid  (i_issue_valid),
    .i_issue_rd     (i_issue_rd),
    .o_rf_reg_write (o_rf_reg_write),
    .o_rf_rd        (o_rf_rd),
    .o_rf_rd_din    (o_rf_rd_din),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  int          acc_src = -1;
  int          last_g = NUM_SRC - 1;
  logic [31:0] m_busy = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: pick the winner from the spec's priority rule, then predict the next-cycle RF port and scoreboard.
  always @(negedge i_clk) begin
    int          g;
    int          s;
    logic [31:0] nb;
    exp_t        e;
    if (chk_en && i_rst_n) begin
      g = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
`ifdef RF_WB_RR_ARB_EN
        s = (last_g + 1 + k) % NUM_SRC;
`else
        s = k;
`endif
        if (g < 0 && i_wb_valid[s]) g = s;
      end
      check("ready", 64'(o_wb_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      nb = m_busy;
      e  = '0;
      if (g >= 0) begin
        e.rd   = i_wb_rd[g*5 +: 5];
        e.data = i_wb_data[g*XLEN +: XLEN];
        e.wr   = (e.rd != 5'd0);
        nb[e.rd] = 1'b0;
        last_g = g;
      end
      if (i_issue_valid) nb[i_issue_rd] = 1'b1;
      nb[0]   = 1'b0;
      m_busy  = nb;
      e.busy  = nb;
      acc_src = g;
      exp_q.push_back(e);
    end
  end

  always begin
    exp_t e;
    @(posedge i_clk);
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_reg_write", 64'(o_rf_reg_write), 64'(e.wr));
      if (e.wr) begin
        check("rf_rd", 64'(o_rf_rd), 64'(e.rd));
        check("rf_rd_din", 64'(o_rf_rd_din), 64'(e.data));
      end
      check("busy", 64'(o_busy), 64'(e.busy));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    if (chk_en && acc_src >= 0) i_wb_valid[acc_src] = 1'b0;
    i_issue_valid = 1'b0;
  endtask

  task automatic put(input int s, input logic [4:0] rd, input logic [31:0] data);
    i_wb_valid[s]           = 1'b1;
    i_wb_rd[s*5 +: 5]       = rd;
    i_wb_data[s*XLEN +: XLEN] = data;
  endtask

  task automatic issue(input logic [4:0] rd);
    i_issue_valid = 1'b1;
    i_issue_rd    = rd;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (i_wb_valid != '0 && n < 40) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 64'(i_wb_valid != '0), 64'd0);
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_wb_valid    = '0;
    i_wb_rd       = '0;
    i_wb_data     = '0;
    i_issue_valid = 1'b0;
    i_issue_rd    = '0;
    repeat (2) @(posedge i_clk);
    #1;

    // Reset mid-transfer: request is visible, then reset drops it.
    i_rst_n = 1'b1;
    issue(5'd5);
    put(1, 5'd5, 32'h5555_AAAA);
    #2;
    check("t1_ready_before", 64'(o_wb_ready), 64'b010);
    i_rst_n = 1'b0;
    #1;
    check("t1_ready_in_reset", 64'(o_wb_ready), 64'd0);
    step();
    check("t1_reg_write", 64'(o_rf_reg_write), 64'd0);
    check("t1_busy", 64'(o_busy), 64'd0);
    check("t1_rd", 64'(o_rf_rd), 64'd0);
    check("t1_din", 64'(o_rf_rd_din), 64'd0);
    i_rst_n    = 1'b1;
    i_wb_valid = '0;
    chk_en     = 1'b1;

    // Single source with scoreboard lifetime.
    issue(5'd7);
    repeat (3) step();
    put(2, 5'd7, 32'hDEAD_BEEF);
    drain("t2");
    step();

    // Three-way contention, held until each is accepted.
    issue(5'd1); step();
    issue(5'd2); step();
    issue(5'd3); step();
    put(0, 5'd1, $urandom);
    put(1, 5'd2, $urandom);
    put(2, 5'd3, $urandom);
    drain("t3");

    // Issue and acceptance hit the same register in one cycle.
    issue(5'd9); step();
    put(0, 5'd9, 32'h0000_0909);
    issue(5'd9);
    drain("t4");

    // x0 destination consumes the grant without writing.
    put(1, 5'd0, 32'h0000_1234);
    issue(5'd0);
    drain("t5");

    // Back-to-back beats from one source with changing data.
    for (int b = 0; b < 6; b++) begin
      put(0, 5'(b + 10), $urandom);
      step();
    end
    drain("t6");

    for (int c = 0; c < 500; c++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (!i_wb_valid[s] && ($urandom % 3) == 0) put(s, 5'($urandom % 32), $urandom);
      end
      if ($urandom % 2) issue(5'($urandom % 32));
      step();
    end
    drain("rand");
    repeat (2) step();
    chk_en = 1'b0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
